vote_sweep_ctrl: RTL and testbench
==================================

Name: vote_sweep_ctrl

Overview:
Self-test sequencer for the 4-input 3-of-4 vote evaluator. The evaluator function is out = A·B·(C+D) + C·D·(A+B).
- On start, drives all 16 input vectors onto A..D in ascending order.
- Holds each vector for DWELL cycles, then samples the evaluator result and compares it against the golden 3-of-4 function.
- Reports pass/fail, the mismatch count and the first failing vector.
- Sits beside the evaluator and replaces the free-running stimulus generator for in-system checking.

Parameters:
DWELL, 2, cycles each vector is held before its result is sampled; legal range 1..15; 0 is illegal.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  cancel the sweep in progress.
- eval_out  in  1  result from the evaluator under test.
- A  out  1  evaluator input A; vector bit 3.
- B  out  1  evaluator input B; vector bit 2.
- C  out  1  evaluator input C; vector bit 1.
- D  out  1  evaluator input D; vector bit 0.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at sweep completion.
- pass  out  1  result of the last completed sweep: 1 when err_cnt==0.
- err_cnt  out  5  number of mismatches in the current or last sweep; range 0..16.
- first_err_valid  out  1  at least one mismatch has been recorded.
- first_err_vec  out  4  {A,B,C,D} of the first mismatch.

Behaviour:
- States: IDLE, SWEEP, DONE.
- Reset (rst_n=0 at an edge): state=IDLE, vector v=0, dwell counter=0.
  - All outputs are 0: A..D, busy, done, pass, err_cnt, first_err_valid, first_err_vec.
  - Reset wins over start and abort. Reset mid-sweep discards the sweep; no done pulse.
- IDLE:
  - A..D=0, busy=0.
  - start=1 at an edge → SWEEP, busy=1, v=0, dwell=0, err_cnt=0, first_err_valid=0, first_err_vec=0, pass=0.
- SWEEP:
  - {A,B,C,D}=v, driven from registers (no combinational path from inputs).
  - dwell counts 0..DWELL-1 and holds each vector for exactly DWELL cycles.
  - At the edge where dwell==DWELL-1, sample eval_out and compare against expected = (popcount(v) >= 3).
  - On mismatch: err_cnt increments by 1. If first_err_valid==0, also load first_err_vec=v and set first_err_valid=1.
  - After the compare: if v==15 go to DONE; otherwise v increments and dwell resets to 0.
  - start is ignored while in SWEEP.
- Sample timing: with start sampled at edge k, vector n is sampled at edge k+(n+1)·DWELL. The last sample is at edge k+16·DWELL.
- DONE (entered at the edge of the last sample):
  - done=1 for exactly one cycle, busy=0, A..D=0.
  - pass is valid in this cycle and equals (final err_cnt==0), including the result for v=15.
  - Next edge → IDLE. start is ignored while in DONE.
- abort=1 at an edge while in SWEEP: next state IDLE, busy=0, A..D=0, no done pulse.
  - err_cnt, first_err_valid and first_err_vec keep their partial values.
  - pass stays 0.
  - abort is ignored in IDLE and DONE.
  - If abort and the last sample coincide, abort wins: no done pulse, and that final compare is discarded.
- Holding after completion: pass, err_cnt, first_err_valid and first_err_vec hold their values until the next accepted start or reset.
- Widths: err_cnt maximum is 16, so it never wraps. The dwell counter is 4 bits.

Test Plan:
1. DWELL=2, eval_out driven by a correct evaluator, start pulsed at edge k → done high only in the cycle after edge k+32; pass=1, err_cnt=0, first_err_valid=0. A..D step through 0000..1111, each vector held 2 cycles.
2. eval_out stuck at 0 → err_cnt=5 (vectors 0111, 1011, 1101, 1110, 1111), pass=0, first_err_vec=4'b0111, first_err_valid=1.
3. eval_out stuck at 1 → err_cnt=11, first_err_vec=4'b0000, pass=0.
   - Extend this scenario: with DWELL=1, done occurs 16 cycles after the start edge.
4. Start pulsed again mid-sweep and during DONE → ignored; sweep timing unchanged; exactly one done pulse.
5. Abort while v=6 (golden evaluator) → busy=0 and A..D=0 after the next edge; no done pulse; err_cnt=0.
   - Then start again → full sweep passes.
   - Repeat with abort coinciding with the v=15 sample → no done pulse.
6. rst_n=0 for one edge while v=9 with err_cnt=3 (fault injected) → all outputs 0 on the following cycle, state IDLE.
   - A start issued in the same cycle as the reset is not honoured.

Source files
------------

// File: rtl/vote_sweep_ctrl.sv
// Self-test sequencer for the 3-of-4 vote evaluator: walks all 16 input vectors,
// compares each sampled result against the golden majority function and reports the outcome.
module vote_sweep_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       eval_out,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       first_err_valid,
    output logic [3:0] first_err_vec
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [3:0] v_q, v_d;
    logic [3:0] dwell_q, dwell_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic       fev_q, fev_d;
    logic [3:0] fevec_q, fevec_d;

    logic       golden;
    logic       mismatch;
    logic [4:0] err_next;

    assign golden   = (v_q[3] & v_q[2] & (v_q[1] | v_q[0])) | (v_q[1] & v_q[0] & (v_q[3] | v_q[2]));
    assign mismatch = eval_out ^ golden;
    assign err_next = err_cnt_q + {4'd0, mismatch};

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        dwell_d   = dwell_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        fev_d     = fev_q;
        fevec_d   = fevec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SWEEP;
                    busy_d    = 1'b1;
                    v_d       = 4'd0;
                    dwell_d   = 4'd0;
                    pass_d    = 1'b0;
                    err_cnt_d = 5'd0;
                    fev_d     = 1'b0;
                    fevec_d   = 4'd0;
                end
            end
            S_SWEEP: begin
                // abort beats a coincident sample: the final compare is dropped
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    v_d     = 4'd0;
                    dwell_d = 4'd0;
                end else if (dwell_q == DWELL_LAST) begin
                    err_cnt_d = err_next;
                    if (mismatch && !fev_q) begin
                        fev_d   = 1'b1;
                        fevec_d = v_q;
                    end
                    dwell_d = 4'd0;
                    if (v_q == 4'hf) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_next == 5'd0);
                        v_d     = 4'd0;
                    end else begin
                        v_d = v_q + 4'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            v_q       <= 4'd0;
            dwell_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 5'd0;
            fev_q     <= 1'b0;
            fevec_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            dwell_q   <= dwell_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fevec_q   <= fevec_d;
        end
    end

    // v is held at zero outside SWEEP, so it drives the evaluator directly
    assign {A, B, C, D}    = v_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fevec_q;

endmodule

// File: tb/tb_vote_sweep_ctrl.sv
// Bench for vote_sweep_ctrl: stub evaluator with injectable faults, sweep outcome predicted
// from the majority rule and the sampling schedule.
module tb_vote_sweep_ctrl;

    localparam int DW = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic       eval0, a0, b0, c0, d0, busy0, done0, pass0, fev0;
    logic [4:0] err0;
    logic [3:0] fevec0;
    logic       eval1, a1, b1, c1, d1, busy1, done1, pass1, fev1;
    logic [4:0] err1;
    logic [3:0] fevec1;

    int          mode;
    logic [15:0] flip;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // evaluator stub: 0 = majority xor flip mask, 1 = stuck at 0, 2 = stuck at 1
    function automatic logic ev(input logic [3:0] v);
        logic maj;
        maj = (v[3] & v[2] & (v[1] | v[0])) | (v[1] & v[0] & (v[3] | v[2]));
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return maj ^ flip[v];
        endcase
    endfunction

    function automatic bit is_err(input int v);
        logic [3:0] vv;
        vv = 4'(v);
        return ev(vv) != ($countones(vv) >= 3);
    endfunction

    assign eval0 = ev({a0, b0, c0, d0});
    assign eval1 = ev({a1, b1, c1, d1});

    vote_sweep_ctrl #(.DWELL(DW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eval_out(eval0),
        .A(a0), .B(b0), .C(c0), .D(d0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .first_err_valid(fev0), .first_err_vec(fevec0)
    );

    vote_sweep_ctrl #(.DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eval_out(eval1),
        .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .first_err_valid(fev1), .first_err_vec(fevec1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on dut0; ab >= 0 asserts abort in cycle ab after the start edge.
    task automatic run_sweep(input string nm, input int md, input logic [15:0] fl,
                             input bit noise, input int ab, input bit chk1);
        bit  aborted = 0;
        int  cut = 0, ndone = 0, sdone, eerr, first;
        int  ev_vec;
        bit  edone, epass;
        mode = md;
        flip = fl;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= 16*DW + 2; j++) begin
            sdone = aborted ? cut : ((j / DW) > 16 ? 16 : (j / DW));
            eerr = 0;
            first = -1;
            for (int v = 0; v < sdone; v++)
                if (is_err(v)) begin
                    eerr++;
                    if (first < 0) first = v;
                end
            edone  = !aborted && (j == 16*DW);
            epass  = !aborted && (j >= 16*DW) && (eerr == 0);
            ev_vec = (aborted || j >= 16*DW) ? 0 : j / DW;
            if (done0) ndone++;
            n_chk++;
            if ({a0, b0, c0, d0} !== 4'(ev_vec) || busy0 !== (!aborted && j < 16*DW) || done0 !== edone) begin
                n_fail++;
                $display("FAIL %s ctl j=%0d: vec=%h busy=%b done=%b, want vec=%h busy=%b done=%b",
                         nm, j, {a0, b0, c0, d0}, busy0, done0, ev_vec, !aborted && j < 16*DW, edone);
            end
            n_chk++;
            if (err0 !== 5'(eerr) || fev0 !== (first >= 0) || fevec0 !== 4'(first < 0 ? 0 : first) || pass0 !== epass) begin
                n_fail++;
                $display("FAIL %s res j=%0d: err=%0d fev=%b fvec=%h pass=%b, want err=%0d fev=%b fvec=%h pass=%b",
                         nm, j, err0, fev0, fevec0, pass0, eerr, first >= 0, 4'(first < 0 ? 0 : first), epass);
            end
            if (chk1 && j <= 18) begin
                n_chk++;
                if (done1 !== (j == 16) || busy1 !== (j < 16)) begin
                    n_fail++;
                    $display("FAIL %s dwell1 j=%0d: done=%b busy=%b, want done=%b busy=%b",
                             nm, j, done1, busy1, j == 16, j < 16);
                end
                if (j == 17) begin
                    n_chk++;
                    if (err1 !== 5'd11 || fevec1 !== 4'd0 || fev1 !== 1'b1 || pass1 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s dwell1 result: err=%0d fvec=%h fev=%b pass=%b, want 11 0 1 0",
                                 nm, err1, fevec1, fev1, pass1);
                    end
                end
            end
            abort = (j == ab);
            if (noise) start = (j < 16*DW) ? 1'($urandom_range(0, 1)) : (j == 16*DW);
            if (j == ab) begin
                aborted = 1;
                cut = j / DW;
            end
            tick();
            abort = 1'b0;
            start = 1'b0;
        end
        n_chk++;
        if (ndone !== (ab < 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d want %0d", nm, ndone, ab < 0 ? 1 : 0);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; abort = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({a0, b0, c0, d0, busy0, done0, pass0, err0, fev0, fevec0} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0", {a0, b0, c0, d0, busy0, done0, pass0, err0, fev0, fevec0});
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_mid_reset();
        logic [15:0] fl = '0;
        int lo = 9;
        while ($countones(fl) < 3) fl[$urandom_range(0, 8)] = 1'b1;
        for (int v = 8; v >= 0; v--) if (fl[v]) lo = v;
        mode = 0; flip = fl;
        start = 1'b1; tick(); start = 1'b0;
        repeat (18) tick();
        n_chk++;
        if ({a0, b0, c0, d0} !== 4'd9 || err0 !== 5'd3 || fevec0 !== 4'(lo)) begin
            n_fail++;
            $display("FAIL midreset_pre: vec=%h err=%0d fvec=%h, want 9 3 %h", {a0, b0, c0, d0}, err0, fevec0, 4'(lo));
        end
        rst_n = 1'b0; start = 1'b1;
        tick();
        n_chk++;
        if ({a0, b0, c0, d0, busy0, done0, pass0, err0, fev0, fevec0} !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %b want 0", {a0, b0, c0, d0, busy0, done0, pass0, err0, fev0, fevec0});
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (3) tick();
        n_chk++;
        if (busy0 !== 1'b0 || {a0, b0, c0, d0} !== 4'd0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: busy=%b vec=%h done=%b, want 0 0 0", busy0, {a0, b0, c0, d0}, done0);
        end
    endtask

    task automatic test_golden();       run_sweep("golden", 0, 16'h0, 0, -1, 0); endtask
    task automatic test_stuck0();       run_sweep("stuck0", 1, 16'h0, 0, -1, 0); endtask
    task automatic test_stuck1();       run_sweep("stuck1", 2, 16'h0, 0, -1, 1); endtask
    task automatic test_start_ignored(); run_sweep("restart", 0, 16'h0240, 1, -1, 0); endtask

    task automatic test_abort();
        run_sweep("abort_v6", 0, 16'h0, 0, 12, 0);
        run_sweep("after_abort", 0, 16'h0, 0, -1, 0);
        run_sweep("abort_last", 0, 16'h8000, 0, 31, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            run_sweep("random", 0, 16'($urandom), 0, (i == 5) ? int'($urandom_range(0, 31)) : -1, 0);
        end
    endtask

    initial begin
        mode = 0; flip = '0; start = 1'b0; abort = 1'b0; rst_n = 1'b0;
        test_reset();
        test_golden();
        test_stuck0();
        test_stuck1();
        test_start_ignored();
        test_abort();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
